// File: rtl/bitstream_bit_server.sv
// Bit server between a byte source and the arithmetic decoder.
// Keeps an MSB-first bit buffer topped up from the byte source and serves
// variable-length reads (0..MAX_BITS bits) over a req/ack handshake.
// A read that can never be satisfied parks the block in a sticky EOS state.
module bitstream_bit_server #(
    parameter int MAX_BITS = 16,
    parameter int BUF_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    output logic                byte_req,
    input  logic                bits_req,
    input  logic [4:0]          bits_num,
    output logic                bits_ack,
    output logic [MAX_BITS-1:0] bits_data,
    output logic [5:0]          bits_avail,
    output logic                eos
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] REFILL_MAX = CNT_W'(BUF_W - 8);
    localparam logic [CNT_W-1:0] BUF_BITS   = CNT_W'(BUF_W);
    localparam logic [4:0]       MAX_N      = 5'(MAX_BITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_EOS  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    bitbuf_q, bitbuf_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [MAX_BITS-1:0] data_q, data_d;

    logic [4:0]          n_clamp;
    logic [CNT_W-1:0]    n_ext;
    logic                short_buf;
    logic                serve;
    logic [BUF_W-1:0]    shifted;
    logic [CNT_W-1:0]    cnt_post;

    // Clamp the request size and decide whether the buffer can cover it now.
    always_comb begin
        n_clamp   = (bits_num > MAX_N) ? MAX_N : bits_num;
        n_ext     = CNT_W'(n_clamp);
        short_buf = (count_q < n_ext);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; serve marks the edge at which a read is taken out.
    // WAIT re-evaluates every cycle while refills land; a dropped request
    // (protocol violation) simply falls back to IDLE with nothing consumed.
    always_comb begin
        state_d = state_q;
        serve   = 1'b0;
        case (state_q)
            S_IDLE, S_WAIT: begin
                if (!bits_req) begin
                    state_d = S_IDLE;
                end else if (!short_buf) begin
                    state_d = S_ACK;
                    serve   = 1'b1;
                end else if (byte_valid) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_EOS;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_EOS:   state_d = S_EOS;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: refill request is gated by reset so nothing is consumed while
    // the block is held; the threshold uses the pre-serve count, which keeps
    // the post-serve insertion point inside the buffer.
    always_comb begin
        byte_req = !rst && byte_valid && (count_q <= REFILL_MAX) && (state_q != S_EOS);
        bits_ack = (state_q == S_ACK);
        eos      = (state_q == S_EOS);
    end

    // Datapath: shift out the served bits first, then drop the new byte in
    // directly behind whatever remains. Bits below the fill level stay zero,
    // so OR-ing the byte in is safe.
    always_comb begin
        shifted  = serve ? (bitbuf_q << n_clamp) : bitbuf_q;
        cnt_post = serve ? (count_q - n_ext) : count_q;
        bitbuf_d = shifted;
        count_d  = cnt_post;
        if (byte_req) begin
            bitbuf_d = shifted | ({byte_data, {(BUF_W-8){1'b0}}} >> cnt_post);
            count_d  = cnt_post + CNT_W'(8);
        end
        // A shift by the full width yields zero, which covers the null read.
        data_d = serve ? MAX_BITS'(bitbuf_q >> (BUF_BITS - n_ext)) : data_q;
    end

    // Buffer, fill count and served-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitbuf_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            bitbuf_q <= bitbuf_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    assign bits_data  = data_q;
    assign bits_avail = count_q;

endmodule

// File: tb/tb_bitstream_bit_server.sv
// Directed bench for bitstream_bit_server: per-cycle vector tables plus
// hand-written sequences around reset.
module tb_bitstream_bit_server;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_req;
    logic        bits_req;
    logic [4:0]  bits_num;
    logic        bits_ack;
    logic [15:0] bits_data;
    logic [5:0]  bits_avail;
    logic        eos;

    always #5 clk = ~clk;

    bitstream_bit_server dut (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_req   (byte_req),
        .bits_req   (bits_req),
        .bits_num   (bits_num),
        .bits_ack   (bits_ack),
        .bits_data  (bits_data),
        .bits_avail (bits_avail),
        .eos        (eos)
    );

    // Byte source model: advances on a sampled byte_req, exhausted past slen.
    logic [7:0] stream [0:15];
    logic [4:0] idx = 5'd0;
    logic [4:0] slen = 5'd0;
    logic       src_load = 1'b0;

    always @(posedge clk) begin
        if (src_load)      idx <= 5'd0;
        else if (byte_req) idx <= idx + 5'd1;
    end

    assign byte_data  = stream[idx[3:0]];
    assign byte_valid = (idx < slen);

    typedef struct {
        logic        req;
        logic [4:0]  num;
        logic        br;
        logic [5:0]  av;
        logic        ack;
        logic [15:0] data;
        logic        eos;
    } vec_t;

    vec_t tv [0:79];
    int   nv = 0;
    int   seg [0:7];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    task automatic add(input logic req, input logic [4:0] num, input logic br, input logic [5:0] av,
                       input logic ack, input logic [15:0] data, input logic e);
        tv[nv].req  = req;
        tv[nv].num  = num;
        tv[nv].br   = br;
        tv[nv].av   = av;
        tv[nv].ack  = ack;
        tv[nv].data = data;
        tv[nv].eos  = e;
        nv++;
    endtask

    // Reset the DUT and source together with a new byte stream (MSB-first pack).
    task automatic load(input int n, input logic [63:0] bytes);
        @(negedge clk);
        rst = 1'b1;
        bits_req = 1'b0;
        bits_num = 5'd0;
        src_load = 1'b1;
        for (int i = 0; i < 8; i++) stream[i] = bytes[63-8*i -: 8];
        slen = 5'(n);
        @(negedge clk);
        src_load = 1'b0;
        rst = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bits_req = tv[i].req;
            bits_num = tv[i].num;
            #1;
            chk("byte_req",   i, 32'(byte_req),   32'(tv[i].br));
            chk("bits_avail", i, 32'(bits_avail), 32'(tv[i].av));
            chk("bits_ack",   i, 32'(bits_ack),   32'(tv[i].ack));
            chk("bits_data",  i, 32'(bits_data),  32'(tv[i].data));
            chk("eos",        i, 32'(eos),        32'(tv[i].eos));
            @(negedge clk);
        end
        bits_req = 1'b0;
    endtask

    initial begin
        bits_req = 1'b0;
        bits_num = 5'd0;
        for (int i = 0; i < 16; i++) stream[i] = 8'h00;

        // A: stream A5 3C F0 0F 12 34 -- fill to 32, then reads of 9 and 7
        seg[0] = nv;
        add(0, 0,  1, 0,  0, 16'h0,   0);
        add(0, 0,  1, 8,  0, 16'h0,   0);
        add(0, 0,  1, 16, 0, 16'h0,   0);
        add(0, 0,  1, 24, 0, 16'h0,   0);
        add(0, 0,  0, 32, 0, 16'h0,   0);
        add(0, 0,  0, 32, 0, 16'h0,   0);
        add(1, 9,  0, 32, 0, 16'h0,   0);
        add(1, 7,  1, 23, 1, 16'h14A, 0);
        add(1, 7,  0, 31, 0, 16'h14A, 0);
        add(0, 0,  1, 24, 1, 16'h03C, 0);
        add(0, 0,  0, 32, 0, 16'h03C, 0);
        // B: stream 11 22 33 44 55 66 -- serve and refill on the same edge
        seg[1] = nv;
        add(0, 0,  1, 0,  0, 16'h0,    0);
        add(0, 0,  1, 8,  0, 16'h0,    0);
        add(0, 0,  1, 16, 0, 16'h0,    0);
        add(1, 4,  1, 24, 0, 16'h0,    0);
        add(1, 16, 0, 28, 1, 16'h1,    0);
        add(1, 16, 0, 28, 0, 16'h1,    0);
        add(0, 0,  1, 12, 1, 16'h1223, 0);
        add(1, 12, 1, 20, 0, 16'h1223, 0);
        add(0, 0,  0, 16, 1, 16'h0344, 0);
        add(1, 16, 0, 16, 0, 16'h0344, 0);
        add(0, 0,  0, 0,  1, 16'h5566, 0);
        // C: stream FF 00 then exhausted -- 16-bit read, then EOS
        seg[2] = nv;
        add(0, 0,  1, 0,  0, 16'h0,    0);
        add(0, 0,  1, 8,  0, 16'h0,    0);
        add(1, 16, 0, 16, 0, 16'h0,    0);
        add(1, 1,  0, 0,  1, 16'hFF00, 0);
        add(1, 1,  0, 0,  0, 16'hFF00, 0);
        add(1, 1,  0, 0,  0, 16'hFF00, 1);
        add(1, 1,  0, 0,  0, 16'hFF00, 1);
        add(0, 0,  0, 0,  0, 16'hFF00, 1);
        // D: stream 81 42 C3 -- null read at 17 bits, clamped 20 -> 16
        seg[3] = nv;
        add(0, 0,  1, 0,  0, 16'h0,    0);
        add(0, 0,  1, 8,  0, 16'h0,    0);
        add(0, 0,  1, 16, 0, 16'h0,    0);
        add(1, 7,  0, 24, 0, 16'h0,    0);
        add(1, 0,  0, 17, 1, 16'h0040, 0);
        add(1, 0,  0, 17, 0, 16'h0040, 0);
        add(1, 20, 0, 17, 1, 16'h0,    0);
        add(1, 20, 0, 17, 0, 16'h0,    0);
        add(1, 1,  0, 1,  1, 16'hA161, 0);
        add(1, 1,  0, 1,  0, 16'hA161, 0);
        add(0, 0,  0, 0,  1, 16'h0001, 0);
        // E: stream AA BB CC DD -- enter WAIT with 8 bits and a 16-bit request
        seg[4] = nv;
        add(0, 0,  1, 0,  0, 16'h0,    0);
        add(1, 16, 1, 8,  0, 16'h0,    0);
        // F: after reset release the source resumes at CC
        seg[5] = nv;
        add(0, 0,  1, 0,  0, 16'h0,    0);
        add(1, 8,  1, 8,  0, 16'h0,    0);
        add(0, 0,  0, 8,  1, 16'h00CC, 0);
        seg[6] = nv;

        // Reset state while rst is held at time zero.
        #1;
        chk("rst_byte_req", -1, 32'(byte_req),   32'd0);
        chk("rst_avail",    -1, 32'(bits_avail), 32'd0);
        chk("rst_ack",      -1, 32'(bits_ack),   32'd0);
        chk("rst_data",     -1, 32'(bits_data),  32'd0);
        chk("rst_eos",      -1, 32'(eos),        32'd0);

        load(6, 64'hA53CF00F1234_0000);
        run_rows(seg[0], seg[1]);

        load(6, 64'h112233445566_0000);
        run_rows(seg[1], seg[2]);

        load(2, 64'hFF00_0000_0000_0000);
        run_rows(seg[2], seg[3]);
        // Reset out of EOS clears the sticky flag and the held data at once.
        rst = 1'b1;
        #1;
        chk("eos_rst_eos",  -1, 32'(eos),       32'd0);
        chk("eos_rst_data", -1, 32'(bits_data), 32'd0);
        chk("eos_rst_br",   -1, 32'(byte_req),  32'd0);

        load(3, 64'h8142C3_0000000000);
        run_rows(seg[3], seg[4]);

        load(4, 64'hAABBCCDD_00000000);
        run_rows(seg[4], seg[5]);
        // Still waiting on more bits: 16 buffered, no ack yet.
        bits_req = 1'b1;
        bits_num = 5'd16;
        #1;
        chk("wait_avail", -1, 32'(bits_avail), 32'd16);
        chk("wait_ack",   -1, 32'(bits_ack),   32'd0);
        // Reset mid-WAIT with the request still held: outputs drop immediately.
        rst = 1'b1;
        #1;
        chk("wrst_byte_req", -1, 32'(byte_req),   32'd0);
        chk("wrst_avail",    -1, 32'(bits_avail), 32'd0);
        chk("wrst_ack",      -1, 32'(bits_ack),   32'd0);
        chk("wrst_eos",      -1, 32'(eos),        32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("wrst_hold_br", -1, 32'(byte_req), 32'd0);
        rst = 1'b0;
        bits_req = 1'b0;
        run_rows(seg[5], seg[6]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bitstream_bit_server.md
Name: bitstream_bit_server

Overview:
- Sits between the byte-stream source (byte + data_ready, advanced by a request sampled on the clock edge) and the arithmetic decoder core.
- Keeps a 32-bit MSB-first bit buffer topped up from the byte source.
- Serves variable-length bit reads (1..16 bits) to the decoder through a req/ack handshake. Typical reads are the 9-bit range/offset initialisation and bypass/renormalisation bits.
- Flags end-of-stream when a read cannot be satisfied.

Parameters:
- MAX_BITS, 16, largest bit count served per read; bits_data width.
- BUF_W, 32, bit buffer width; refill threshold is BUF_W-8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- byte_data  in  8  current byte from source; meaningful only when byte_valid=1.
- byte_valid  in  1  source has a byte; 0 means stream exhausted (sticky at source).
- byte_req  out  1  consume byte_data at this posedge; source presents next byte (or drops byte_valid) after the edge.
- bits_req  in  1  decoder read request; held with bits_num stable until bits_ack.
- bits_num  in  5  bits requested; 1..16 legal, 0 = null read, 17..31 clamped to 16.
- bits_ack  out  1  one-cycle pulse: bits_data valid.
- bits_data  out  MAX_BITS  served bits, right-aligned, first stream bit at the MSB of the field, upper bits 0; held until next ack.
- bits_avail  out  6  current buffer fill count (0..32).
- eos  out  1  sticky: a pending read needs more bits than buffer + source can supply.

Behaviour:
- Reset (async, immediate): buffer=0, count=0, bits_ack=0, bits_data=0, eos=0, state=IDLE.
  - byte_req is forced 0 while rst=1.
  - Bytes already consumed are discarded and not replayed.
- Buffer: valid bits occupy buf[31 -: count]. Stream order is MSB-first per byte, earlier bytes at higher bits.
- Refill (combinational): byte_req = !rst && byte_valid && (count <= 24).
  - On that posedge, byte_data is inserted at buf[31-c' -: 8], where c' is count after any same-cycle serve.
  - count increases by 8.
- Serve: let n = clamp(bits_num).
  - A read is accepted at a posedge when state=IDLE, bits_req=1, bits_ack=0, and count >= n.
  - On acceptance: bits_data <= buf[31 -: n] right-aligned; buf <= buf << n; count -= n.
  - bits_ack is 1 for exactly the following cycle.
  - Latency: ack in the cycle after the accepting edge.
  - Requests are ignored during the ack cycle, so the maximum throughput is one read per 2 cycles.
- Simultaneous serve + refill in one edge is required. New count = count - n + 8; insertion uses the post-shift position. The refill condition uses the pre-serve count, which guarantees c' <= 24.
- Null read (n=0): accepted whenever IDLE and req; acks with bits_data=0; buffer unchanged.
- FSM states:
  - IDLE: waiting for a request.
  - WAIT: req pending, count < n, byte_valid=1; refill in progress; re-evaluate every cycle.
  - ACK: one cycle; always returns to IDLE.
  - EOS: entered from IDLE/WAIT when req pending, count < n, byte_valid=0. eos <= 1; no ack is ever issued. Only rst leaves EOS.
  - Transitions: IDLE->ACK on acceptance; IDLE->WAIT on a short buffer; WAIT->ACK once satisfied.
- Refill continues in every state except EOS and reset, while count <= 24 and byte_valid=1.
- bits_avail reflects the registered count.
- bits_req deasserted without an ack (protocol violation): return to IDLE with no side effects.

Test Plan:
- Stream A5 3C F0 0F 12 34, reset release, no req:
  - byte_req high 4 consecutive cycles; bits_avail 8,16,24,32 then holds.
  - byte_req then stays low.
- Same stream, req n=9 then n=7:
  - First ack: bits_data=0x14A, bits_avail 23, then 31 after refill with 0x12.
  - Second ack: bits_data=0x3C.
- Serve+refill same edge: count=24, byte_valid=1, n=4 accepted:
  - count becomes 28.
  - Inserted byte sits directly after the remaining 20 bits; a later 16-bit read returns the correct order.
- Stream FF 00 then exhausted, n=16:
  - Ack with 0xFF00.
  - Next n=1 raises eos=1 within 2 cycles, bits_ack never asserts, bits_avail=0.
- bits_num=0 with count=17: ack next cycle, bits_data=0, bits_avail stays 17. bits_num=20 behaves as 16.
- rst asserted mid-WAIT (req n=16, count=8):
  - Outputs zero immediately, byte_req=0, eos=0.
  - After release, refill restarts from the source's current byte.
